bcd_seg_scan: RTL and testbench

//   Multiplexed 7-segment display driver for packed BCD digits from the bcd counter stage(s).

---
 rtl/bcd_seg_scan.sv | 156 +++++++++++++++
 tb/tb_bcd_seg_scan.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: multiplexed 7-segment driver for packed BCD digits.
//   A load strobe captures a new digit word into a pending buffer. The pending
//   word moves into the displayed (shadow) word only at a frame boundary, so a
//   frame never mixes two words. One digit is scanned per refresh slot, with
//   optional leading-zero blanking and an error flag for codes above 9.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   digits_in  packed BCD word, digit0 = [3:0] (least significant)
//   load       capture digits_in into the pending buffer this cycle
//   blank_lz   1 = blank leading zeros (sampled on each slot tick)
//   seg        segments {g,f,e,d,c,b,a}, active-high, registered
//   an         one-hot digit enable, active-high, registered
//   err        1 while the displayed digit code is above 9, registered
//   frame_done 1-cycle pulse when the last digit slot starts
module bcd_seg_scan #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    err,
    output logic                    frame_done
);

    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [DATA_W-1:0]     shadow_q,  shadow_d;
    logic [DATA_W-1:0]     pending_q, pending_d;
    logic                  pv_q,      pv_d;
    logic [6:0]            seg_q,     seg_d;
    logic [NUM_DIGITS-1:0] an_q,      an_d;
    logic                  err_q,     err_d;
    logic                  fd_q,      fd_d;

    logic                  tick_c;
    logic                  boundary_c;
    logic [3:0]            digit_c;
    logic                  blank_c;
    logic [NUM_DIGITS-1:0] zero_hi_c;

    // BCD to gfedcba; codes 10..15 show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign tick_c     = (cnt_q == CNT_LAST);
    assign boundary_c = tick_c && (idx_q == IDX_LAST);

    // zero_hi_c[i] = digit i and every higher digit of the shadow word are zero.
    always_comb begin
        zero_hi_c = '0;
        zero_hi_c[NUM_DIGITS-1] = (shadow_q[DATA_W-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_hi_c[i] = zero_hi_c[i+1] && (shadow_q[4*i +: 4] == 4'd0);
        end
    end

    // Select the digit in the current slot and decide whether it is blanked.
    always_comb begin
        digit_c = 4'd0;
        blank_c = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_c = shadow_q[4*i +: 4];
                blank_c = blank_lz && (i != 0) && zero_hi_c[i];
            end
        end
    end

    // Next-state: prescaler, scan index, buffers and registered outputs.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pv_d      = pv_q;
        seg_d     = seg_q;
        an_d      = an_q;
        err_d     = err_q;
        fd_d      = boundary_c;

        if (tick_c) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            an_d  = NUM_DIGITS'(1) << idx_q;
            seg_d = blank_c ? 7'h00 : seg_decode(digit_c);
            err_d = (digit_c > 4'd9);
        end

        // Transfer uses the old pending word; a coincident load re-arms pending.
        if (boundary_c && pv_q) begin
            shadow_d = pending_q;
            pv_d     = 1'b0;
        end
        if (load) begin
            pending_d = digits_in;
            pv_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            pending_q <= '0;
            pv_q      <= 1'b0;
            seg_q     <= '0;
            an_q      <= '0;
            err_q     <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pv_q      <= pv_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            err_q     <= err_d;
            fd_q      <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign err        = err_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: scoreboard bench for bcd_seg_scan.
//   Expected digit slots are queued as each frame's word is scheduled and are
//   popped whenever the displayed anode changes. A second instance with
//   PRESCALE=1 checks the every-cycle scan rate.
module tb_bcd_seg_scan;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       err;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;
    logic        frame_done;

    logic        f_reset;
    logic [15:0] f_digits;
    logic        f_load;
    logic        f_blank;
    logic [6:0]  f_seg;
    logic [3:0]  f_an;
    logic        f_err;
    logic        f_fd;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   edge_n = 0;
    bit   mon_en = 1'b0;
    logic [3:0] prev_an = 4'd0;
    exp_t sb_q[$];

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    always #5 clk = ~clk;

    bcd_seg_scan #(.NUM_DIGITS(4), .PRESCALE(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .err        (err),
        .frame_done (frame_done)
    );

    bcd_seg_scan #(.NUM_DIGITS(4), .PRESCALE(1)) u_fast (
        .clk        (clk),
        .reset      (f_reset),
        .digits_in  (f_digits),
        .load       (f_load),
        .blank_lz   (f_blank),
        .seg        (f_seg),
        .an         (f_an),
        .err        (f_err),
        .frame_done (f_fd)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue the four slots of one frame displaying word w.
    function automatic void push_frame(input logic [15:0] w, input bit blz);
        exp_t        e;
        logic [3:0]  d;
        logic [15:0] hi;
        for (int i = 0; i < 4; i++) begin
            d     = w[4*i +: 4];
            hi    = w >> (4*i);
            e.an  = 4'(1 << i);
            e.seg = (blz && i > 0 && hi == 16'd0) ? 7'h00 : seg_tbl[d];
            e.err = (d > 4'd9);
            e.fd  = (i == 3);
            sb_q.push_back(e);
        end
    endfunction

    task automatic to_edge(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    // One-cycle load sampled by the DUT at edge e.
    task automatic pulse_load(input int e, input logic [15:0] w);
        to_edge(e - 1);
        digits_in = w;
        load      = 1'b1;
        to_edge(e);
        load      = 1'b0;
    endtask

    // A new slot starts whenever the anode changes; compare it against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (an !== prev_an) begin
                check_eq("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    check_eq("slot", 32'({an, seg, err, frame_done}), 32'(sb_q.pop_front()));
                end
                prev_an = an;
            end else begin
                check_eq("fd_idle", 32'(frame_done), 32'd0);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        digits_in = 16'h0;
        load      = 1'b0;
        blank_lz  = 1'b0;
        f_reset   = 1'b1;
        f_digits  = 16'h0;
        f_load    = 1'b0;
        f_blank   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        edge_n = 0;
        check_eq("rst_an",  32'(an), 32'd0);
        check_eq("rst_seg", 32'(seg), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_fd",  32'(frame_done), 32'd0);

        prev_an = 4'd0;
        mon_en  = 1'b1;
        push_frame(16'h0000, 1'b0);
        push_frame(16'h1234, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            to_edge(e);
            check_eq("pre_tick_an",  32'(an), 32'd0);
            check_eq("pre_tick_seg", 32'(seg), 32'd0);
        end

        pulse_load(7, 16'h1234);

        push_frame(16'h0050, 1'b1);
        pulse_load(22, 16'h0050);
        to_edge(33);
        blank_lz = 1'b1;

        push_frame(16'h0000, 1'b1);
        pulse_load(40, 16'h0000);

        push_frame(16'h00A7, 1'b1);
        pulse_load(55, 16'h00A7);

        push_frame(16'h2222, 1'b1);
        pulse_load(70, 16'h1111);
        pulse_load(74, 16'h2222);

        push_frame(16'h3333, 1'b1);
        push_frame(16'h3333, 1'b1);
        pulse_load(80, 16'h3333);

        pulse_load(122, 16'h9876);
        to_edge(123);
        mon_en = 1'b0;
        reset  = 1'b1;
        to_edge(124);
        reset  = 1'b0;
        check_eq("mid_rst_an",  32'(an), 32'd0);
        check_eq("mid_rst_seg", 32'(seg), 32'd0);
        check_eq("mid_rst_err", 32'(err), 32'd0);
        check_eq("mid_rst_fd",  32'(frame_done), 32'd0);
        sb_q.delete();
        blank_lz = 1'b0;
        edge_n   = 0;
        prev_an  = 4'd0;
        push_frame(16'h0000, 1'b0);
        push_frame(16'h0000, 1'b0);
        mon_en   = 1'b1;

        to_edge(33);
        mon_en = 1'b0;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        check_eq("fast_rst_an", 32'(f_an), 32'd0);
        f_reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check_eq("fast_an", 32'(f_an), 32'(1 << ((k - 1) % 4)));
            check_eq("fast_fd", 32'(f_fd), 32'(((k - 1) % 4) == 3));
            check_eq("fast_seg", 32'(f_seg), 32'h3F);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
